// File: rtl/ram_pkg.sv
// Shared constants for the byte-lane data RAM: default size, lane byte offsets
// and the rw encoding.
package ram_pkg;
    localparam int RAM_DEPTH = 64;
    localparam int LANES     = 4;

    // Big-endian lane order: lane 1h holds the lowest byte address of the word.
    localparam int LANE_1H = 0;
    localparam int LANE_1L = 1;
    localparam int LANE_2H = 2;
    localparam int LANE_2L = 3;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/ram_lane.sv
// One 8-bit lane: byte address, write-enable decode and tri-state read driver.
// Zero-latency read; the pin is released whenever writing, in reset or disabled.
module ram_lane
    import ram_pkg::*;
#(
    parameter int OFFSET = LANE_1H,
    parameter int AW     = 6
) (
    input  logic          reset,
    input  logic          rw,
    input  logic          en,
    input  logic [AW-3:0] index,
    input  logic [7:0]    rdata,
    output logic [AW-1:0] byte_addr,
    output logic          we,
    output logic [7:0]    wdata,
    inout  wire  [7:0]    data
);
    localparam logic [1:0] OFS = 2'(OFFSET);

    logic drive;

    assign byte_addr = {index, OFS};
    assign we        = (rw == RW_WRITE) && en;
    assign wdata     = data;

    // Reset and write cycles both keep the pin released so the master owns the bus.
    assign drive = reset && (rw == RW_READ) && en;
    assign data  = drive ? rdata : 8'bz;
endmodule

// File: rtl/ram.sv
// Byte-addressable data RAM: synchronous per-lane writes, combinational reads.
// Address wraps modulo DEPTH; no backpressure, single port shared by four lanes.
module ram
    import ram_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rw,
    input  logic        en1h,
    input  logic        en1l,
    input  logic        en2h,
    input  logic        en2l,
    inout  wire  [7:0]  data1h,
    inout  wire  [7:0]  data1l,
    inout  wire  [7:0]  data2h,
    inout  wire  [7:0]  data2l
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    Memory [DEPTH];
    logic [AW-3:0] index;
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] we;
    logic [AW-1:0] byte_addr [LANES];
    logic [7:0]    wdata     [LANES];
    logic [7:0]    rdata     [LANES];
    logic          unused_addr;

    // Upper address bits alias; the low two bits select nothing since lanes do.
    assign index       = addr[AW-1:2];
    assign unused_addr = ^{addr[31:AW], addr[1:0]};
    assign lane_en     = {en2l, en2h, en1l, en1h};

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rdata[l] = Memory[byte_addr[l]];
        end
    end

    ram_lane #(.OFFSET(LANE_1H), .AW(AW)) u_lane_1h (
        .reset(reset), .rw(rw), .en(lane_en[LANE_1H]), .index(index),
        .rdata(rdata[LANE_1H]), .byte_addr(byte_addr[LANE_1H]),
        .we(we[LANE_1H]), .wdata(wdata[LANE_1H]), .data(data1h)
    );
    ram_lane #(.OFFSET(LANE_1L), .AW(AW)) u_lane_1l (
        .reset(reset), .rw(rw), .en(lane_en[LANE_1L]), .index(index),
        .rdata(rdata[LANE_1L]), .byte_addr(byte_addr[LANE_1L]),
        .we(we[LANE_1L]), .wdata(wdata[LANE_1L]), .data(data1l)
    );
    ram_lane #(.OFFSET(LANE_2H), .AW(AW)) u_lane_2h (
        .reset(reset), .rw(rw), .en(lane_en[LANE_2H]), .index(index),
        .rdata(rdata[LANE_2H]), .byte_addr(byte_addr[LANE_2H]),
        .we(we[LANE_2H]), .wdata(wdata[LANE_2H]), .data(data2h)
    );
    ram_lane #(.OFFSET(LANE_2L), .AW(AW)) u_lane_2l (
        .reset(reset), .rw(rw), .en(lane_en[LANE_2L]), .index(index),
        .rdata(rdata[LANE_2L]), .byte_addr(byte_addr[LANE_2L]),
        .we(we[LANE_2L]), .wdata(wdata[LANE_2L]), .data(data2l)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                Memory[i] <= 8'h00;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (we[l]) begin
                    Memory[byte_addr[l]] <= wdata[l];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for the byte-lane RAM: expected bus and memory words are
// queued with the stimulus and popped as the DUT responds.
module tb_ram;
    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic        rw;
    logic        en1h, en1l, en2h, en2l;
    wire  [7:0]  data1h, data1l, data2h, data2l;

    logic        drv_on;
    logic [31:0] drv_val;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int n_checks;
    int n_fail;

    assign data1h = drv_on ? drv_val[31:24] : 8'bz;
    assign data1l = drv_on ? drv_val[23:16] : 8'bz;
    assign data2h = drv_on ? drv_val[15:8]  : 8'bz;
    assign data2l = drv_on ? drv_val[7:0]   : 8'bz;

    ram #(.DEPTH(64)) dut (
        .clock(clock), .reset(reset), .addr(addr), .rw(rw),
        .en1h(en1h), .en1l(en1l), .en2h(en2h), .en2l(en2l),
        .data1h(data1h), .data1l(data1l), .data2h(data2h), .data2l(data2l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] bus();
        return {data1h, data1l, data2h, data2l};
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {dut.Memory[a], dut.Memory[a+1], dut.Memory[a+2], dut.Memory[a+3]};
    endfunction

    task automatic set_en(input logic [3:0] m);
        {en1h, en1l, en2h, en2l} = m;
    endtask

    // Starts one time unit after a rising edge, ends one time unit after the next.
    task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        addr = a; rw = 1'b1; set_en(m); drv_val = d; drv_on = 1'b1;
        @(posedge clock); #1;
        rw = 1'b0; drv_on = 1'b0; set_en(4'b0000);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] m);
        addr = a; rw = 1'b0; set_en(m); drv_on = 1'b0;
        #1;
    endtask

    task automatic chk_bus();
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (bus() !== e.exp) begin
            n_fail++;
            $display("FAIL %s: bus got %h want %h", e.name, bus(), e.exp);
        end
    endtask

    task automatic chk_mem(input int a);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (mem_word(a) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Memory[%0d..] got %h want %h", e.name, a, mem_word(a), e.exp);
        end
    endtask

    task automatic test_reset();
        addr = 0; rw = 1'b0; set_en(4'b0000); drv_on = 1'b0; drv_val = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        for (int a = 0; a < 64; a += 4) begin
            sb.push_back('{$sformatf("reset_mem_%0d", a), 32'h0});
            chk_mem(a);
        end
        set_en(4'b1111); #1;
        sb.push_back('{"reset_bus_z", 32'hzzzz_zzzz});
        chk_bus();
        set_en(4'b0000);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_halfword();
        do_write(16, 4'b1100, 32'hAAAA_0000);
        do_write(20, 4'b0011, 32'h0000_A0A0);
        sb.push_back('{"half_rd16", 32'hAAAA_zzzz});
        sb.push_back('{"half_rd20", 32'hzzzz_A0A0});
        sb.push_back('{"half_mem16", 32'hAAAA_0000});
        sb.push_back('{"half_mem20", 32'h0000_A0A0});
        do_read(16, 4'b1100); chk_bus();
        do_read(20, 4'b0011); chk_bus();
        chk_mem(16);
        chk_mem(20);
    endtask

    task automatic test_disabled();
        do_write(24, 4'b0000, 32'hAAAA_AAAA);
        do_write(28, 4'b0000, 32'hA0A0_A0A0);
        sb.push_back('{"dis_rd24", 32'hzzzz_zzzz});
        sb.push_back('{"dis_mem24", 32'h0});
        sb.push_back('{"dis_mem28", 32'h0});
        do_read(24, 4'b0000); chk_bus();
        chk_mem(24);
        chk_mem(28);
    endtask

    task automatic test_full_word();
        do_write(32, 4'b1111, 32'hAAAA_4455);
        do_write(36, 4'b0000, 32'h1234_5678);
        sb.push_back('{"full_rd32", 32'hAAAA_4455});
        sb.push_back('{"full_rd36_z", 32'hzzzz_zzzz});
        sb.push_back('{"full_mem36", 32'h0});
        do_read(32, 4'b1111); chk_bus();
        do_read(36, 4'b0000); chk_bus();
        chk_mem(36);
    endtask

    task automatic test_byte_merge();
        do_write(24, 4'b0100, 32'h00FF_0000);
        do_write(28, 4'b0010, 32'h0000_1100);
        do_write(8,  4'b1000, 32'h2200_0000);
        do_write(12, 4'b0001, 32'h0000_0033);
        sb.push_back('{"byte_rd24", 32'hzzFF_zzzz});
        sb.push_back('{"byte_rd28", 32'hzzzz_11zz});
        sb.push_back('{"byte_rd8",  32'h22zz_zzzz});
        sb.push_back('{"byte_rd12", 32'hzzzz_zz33});
        do_read(24, 4'b0100); chk_bus();
        do_read(28, 4'b0010); chk_bus();
        do_read(8,  4'b1000); chk_bus();
        do_read(12, 4'b0001); chk_bus();
        sb.push_back('{"byte_mem24", 32'h00FF_0000});
        sb.push_back('{"byte_mem28", 32'h0000_1100});
        sb.push_back('{"byte_mem8",  32'h2200_0000});
        sb.push_back('{"byte_mem12", 32'h0000_0033});
        chk_mem(24); chk_mem(28); chk_mem(8); chk_mem(12);
    endtask

    task automatic test_async_reset();
        do_read(32, 4'b1111);
        #1 reset = 1'b0;
        #1;
        sb.push_back('{"arst_bus_z", 32'hzzzz_zzzz});
        chk_bus();
        for (int a = 0; a < 64; a += 4) begin
            sb.push_back('{$sformatf("arst_mem_%0d", a), 32'h0});
            chk_mem(a);
        end
        addr = 24; rw = 1'b1; set_en(4'b1111); drv_val = 32'hDEAD_BEEF; drv_on = 1'b1;
        @(posedge clock); #1;
        rw = 1'b0; drv_on = 1'b0; set_en(4'b0000);
        sb.push_back('{"arst_write_lost", 32'h0});
        chk_mem(24);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_contention();
        do_write(40, 4'b1111, 32'hF0F0_F0F0);
        addr = 40; rw = 1'b1; set_en(4'b1111); drv_val = 32'h0F1E_2D3C; drv_on = 1'b1;
        #1;
        sb.push_back('{"cont_bus_master_only", 32'h0F1E_2D3C});
        chk_bus();
        @(posedge clock); #1;
        sb.push_back('{"cont_bus_after_edge", 32'h0F1E_2D3C});
        chk_bus();
        rw = 1'b0; drv_on = 1'b0; set_en(4'b0000);
        sb.push_back('{"cont_mem40", 32'h0F1E_2D3C});
        chk_mem(40);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        // Address 0x44 wraps onto byte 4 of a 64-byte memory.
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            do_write(32'h0000_0044 + 32'(i * 64), 4'b1111, w);
            sb.push_back('{$sformatf("b2b_rd_%0d", i), w});
            sb.push_back('{$sformatf("b2b_mem_%0d", i), w});
            do_read(4, 4'b1111); chk_bus();
            chk_mem(4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_halfword();
        test_disabled();
        test_full_word();
        test_byte_merge();
        test_async_reset();
        test_contention();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
